// File: rtl/chunked_adder.sv
// Multi-cycle N-bit add/subtract built from a W-bit carry chain, one slice per clock.
//
// state | meaning
// IDLE  | waiting for i_start
// RUN   | one W-bit slice per cycle, LSB slice first
// DONE  | o_done pulse; a new i_start here goes straight back to RUN
module chunked_adder #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic         i_subtract,
    input  logic [N-1:0] i_augend,
    input  logic [N-1:0] i_addend,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_sum,
    output logic         o_carry,
    output logic         o_overflow,
    output logic         o_zero
);
    localparam int CHUNKS = N / W;
    localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  work_q;
    logic          carry_q;
    logic [IW-1:0] idx_q;

    logic [W-1:0]  a_slice;
    logic [W-1:0]  b_slice;
    logic [W:0]    slice_sum;
    logic          carry_top;
    logic [N-1:0]  sum_next;

    always_comb begin
        a_slice   = a_q[idx_q*W +: W];
        b_slice   = b_q[idx_q*W +: W];
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{W{1'b0}}, carry_q};
        // carry into the slice MSB, recovered from its sum bit and operand bits
        carry_top = slice_sum[W-1] ^ a_slice[W-1] ^ b_slice[W-1];
        sum_next  = work_q;
        sum_next[idx_q*W +: W] = slice_sum[W-1:0];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            work_q     <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_sum      <= '0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
            o_zero     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        a_q     <= i_augend;
                        b_q     <= i_subtract ? ~i_addend : i_addend;
                        carry_q <= i_subtract;
                        work_q  <= '0;
                        idx_q   <= '0;
                        o_busy  <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work_q  <= sum_next;
                    carry_q <= slice_sum[W];
                    if (idx_q == LAST) begin
                        state      <= DONE;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        o_sum      <= sum_next;
                        o_carry    <= slice_sum[W];
                        o_overflow <= slice_sum[W] ^ carry_top;
                        o_zero     <= (sum_next == '0);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: directed cases, handshake timing, reset abort,
// random add/sub against an arithmetic model, and a single-slice build.
module tb_chunked_adder;
    logic        clk = 1'b0;
    logic        reset;
    logic        start, subtract;
    logic [31:0] augend, addend;
    logic        o_busy, o_done, o_carry, o_overflow, o_zero;
    logic [31:0] o_sum;

    logic        start8, subtract8;
    logic [7:0]  augend8, addend8;
    logic        busy8, done8, carry8, ovf8, zero8;
    logic [7:0]  sum8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    chunked_adder #(.N(32), .W(8)) u_dut (
        .i_clock(clk), .i_reset(reset), .i_start(start), .i_subtract(subtract),
        .i_augend(augend), .i_addend(addend), .o_busy(o_busy), .o_done(o_done),
        .o_sum(o_sum), .o_carry(o_carry), .o_overflow(o_overflow), .o_zero(o_zero)
    );

    chunked_adder #(.N(8), .W(8)) u_dut8 (
        .i_clock(clk), .i_reset(reset), .i_start(start8), .i_subtract(subtract8),
        .i_augend(augend8), .i_addend(addend8), .o_busy(busy8), .o_done(done8),
        .o_sum(sum8), .o_carry(carry8), .o_overflow(ovf8), .o_zero(zero8)
    );

    // Reference: plain two's-complement arithmetic, returns {sum, carry, ovf, zero}
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub);
        logic [32:0] full;
        logic [31:0] s;
        logic c, v;
        if (sub) begin
            s = a - b;
            c = (a >= b);
            v = (a[31] != b[31]) && (s[31] != a[31]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            s = full[31:0];
            c = full[32];
            v = (a[31] == b[31]) && (s[31] != a[31]);
        end
        return {s, c, v, (s == 32'd0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request in the current cycle (cycle 0) and waits for o_done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          output int done_cyc, output int busy_mask);
        augend = a; addend = b; subtract = sub; start = 1'b1;
        done_cyc = -1;
        busy_mask = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            start = 1'b0;
            if (o_busy) busy_mask |= (1 << c);
            if (o_done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({o_busy, o_done, o_sum, o_carry, o_overflow, o_zero} !== 37'd0) begin
            errors++;
            $display("FAIL reset32 got %h exp 0", {o_busy, o_done, o_sum, o_carry, o_overflow, o_zero});
        end
        checks++;
        if ({busy8, done8, sum8, carry8, ovf8, zero8} !== 13'd0) begin
            errors++;
            $display("FAIL reset8 got %h exp 0", {busy8, done8, sum8, carry8, ovf8, zero8});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({o_busy, o_done} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset got %b exp 00", {o_busy, o_done});
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta[5]   = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'h80000000};
        logic [31:0] tb_[5]  = '{32'h00000001, 32'h00000001, 32'h00000001, 32'd7, 32'h00000001};
        logic        tsub[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [34:0] texp[5] = '{{32'h00000100, 3'b000}, {32'h00000000, 3'b101},
                                 {32'h80000000, 3'b010}, {32'hFFFFFFFE, 3'b000},
                                 {32'h7FFFFFFF, 3'b110}};
        int dc, bm;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb_[i], tsub[i], dc, bm);
            checks++;
            if (dc !== 5) begin
                errors++;
                $display("FAIL dir%0d_done_cycle got %0d exp 5", i, dc);
            end
            checks++;
            if (bm !== 30) begin
                errors++;
                $display("FAIL dir%0d_busy_cycles got %b exp 11110", i, bm);
            end
            checks++;
            if ({o_sum, o_carry, o_overflow, o_zero} !== texp[i]) begin
                errors++;
                $display("FAIL dir%0d_result got %h exp %h", i,
                         {o_sum, o_carry, o_overflow, o_zero}, texp[i]);
            end
        end
    endtask

    task automatic test_ignore_and_back_to_back();
        int dc = -1;
        tick(); tick();
        augend = 32'h12345678; addend = 32'h11111111; subtract = 1'b0; start = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        tick();                                   // cycle 2
        start = 1'b1; augend = $urandom; addend = $urandom; subtract = 1'b1;
        tick();                                   // cycle 3
        augend = $urandom;
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy_c3 got %b%b exp 10", o_busy, o_done);
        end
        tick();                                   // cycle 4
        start = 1'b0; addend = $urandom;
        tick();                                   // cycle 5
        checks++;
        if (o_done !== 1'b1 || {o_sum, o_carry, o_overflow, o_zero} !== {32'h23456789, 3'b000}) begin
            errors++;
            $display("FAIL ignore_result got done=%b %h exp done=1 %h", o_done,
                     {o_sum, o_carry, o_overflow, o_zero}, {32'h23456789, 3'b000});
        end
        start = 1'b1; augend = 32'h40000000; addend = 32'h40000000; subtract = 1'b0;
        tick();                                   // cycle 6
        start = 1'b0;
        checks++;
        if (o_sum !== 32'h23456789 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold got sum=%h busy=%b exp sum=23456789 busy=1", o_sum, o_busy);
        end
        for (int c = 7; c <= 14; c++) begin
            tick();
            if (o_done) begin
                dc = c;
                break;
            end
        end
        checks++;
        if (dc !== 10) begin
            errors++;
            $display("FAIL b2b_done_cycle got %0d exp 10", dc);
        end
        checks++;
        if ({o_sum, o_carry, o_overflow, o_zero} !== {32'h80000000, 3'b010}) begin
            errors++;
            $display("FAIL b2b_result got %h exp %h", {o_sum, o_carry, o_overflow, o_zero},
                     {32'h80000000, 3'b010});
        end
        tick();
        checks++;
        if (o_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width got %b exp 0", o_done);
        end
    endtask

    task automatic test_reset_mid();
        int dc, bm;
        logic seen = 1'b0;
        tick(); tick();
        augend = 32'hDEADBEEF; addend = 32'h01020304; subtract = 1'b0; start = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        tick();                                   // cycle 2
        reset = 1'b1; start = 1'b1; augend = 32'd1; addend = 32'd1;
        tick();                                   // cycle 3
        checks++;
        if ({o_busy, o_done, o_sum, o_carry, o_overflow, o_zero} !== 37'd0) begin
            errors++;
            $display("FAIL reset_mid got %h exp 0", {o_busy, o_done, o_sum, o_carry, o_overflow, o_zero});
        end
        reset = 1'b0; start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (o_done || o_busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done got activity=%b exp 0", seen);
        end
        run_op(32'd3, 32'd4, 1'b0, dc, bm);
        checks++;
        if (dc !== 5 || o_sum !== 32'd7) begin
            errors++;
            $display("FAIL after_reset_op got cycle=%0d sum=%h exp cycle=5 sum=7", dc, o_sum);
        end
    endtask

    task automatic test_random();
        logic [31:0] special[4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] a, b;
        logic        sub;
        logic [34:0] exp_v;
        int dc, bm;
        for (int i = 0; i < 1000; i++) begin
            a = ($urandom_range(0, 7) == 0) ? special[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 7) == 0) ? special[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 15) == 0) b = a;
            sub = $urandom_range(0, 1) == 1;
            exp_v = model(a, b, sub);
            run_op(a, b, sub, dc, bm);
            checks++;
            if (dc !== 5 || {o_sum, o_carry, o_overflow, o_zero} !== exp_v) begin
                errors++;
                $display("FAIL rand%0d a=%h b=%h sub=%b got cycle=%0d %h exp cycle=5 %h", i, a, b,
                         sub, dc, {o_sum, o_carry, o_overflow, o_zero}, exp_v);
            end
        end
    endtask

    task automatic test_single_chunk();
        augend8 = 8'h7F; addend8 = 8'h01; subtract8 = 1'b0; start8 = 1'b1;
        tick();                                   // cycle 1
        start8 = 1'b0;
        checks++;
        if ({busy8, done8} !== 2'b10) begin
            errors++;
            $display("FAIL n8_busy_c1 got %b exp 10", {busy8, done8});
        end
        tick();                                   // cycle 2
        checks++;
        if ({busy8, done8, sum8, carry8, ovf8, zero8} !== {2'b01, 8'h80, 3'b010}) begin
            errors++;
            $display("FAIL n8_add got %h exp %h", {busy8, done8, sum8, carry8, ovf8, zero8},
                     {2'b01, 8'h80, 3'b010});
        end
        tick();
        checks++;
        if (done8 !== 1'b0) begin
            errors++;
            $display("FAIL n8_done_width got %b exp 0", done8);
        end
        augend8 = 8'h10; addend8 = 8'h10; subtract8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        checks++;
        if ({done8, sum8, carry8, ovf8, zero8} !== {1'b1, 8'h00, 3'b101}) begin
            errors++;
            $display("FAIL n8_sub got %h exp %h", {done8, sum8, carry8, ovf8, zero8},
                     {1'b1, 8'h00, 3'b101});
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; subtract = 1'b0; augend = '0; addend = '0;
        start8 = 1'b0; subtract8 = 1'b0; augend8 = '0; addend8 = '0;
        repeat (3) tick();
        test_reset();
        test_directed();
        test_ignore_and_back_to_back();
        test_reset_mid();
        test_random();
        test_single_chunk();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
